// File: rtl/tetris_input_pkg.sv
// Shared types and default timing for the Tetris button input conditioner.
// Defaults assume a 50 MHz system clock.
package tetris_input_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 15000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_R,
    HOLD_L,
    REPEAT_R,
    REPEAT_L
  } rpt_state_e;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tetris_input_conditioner_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and
// rising-edge detect on the accepted level.
module debounce_channel
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // >= rather than == so the counter can never run past the limit
      if (cnt_q >= LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = stable_q & ~prev_q;

endmodule

// File: rtl/tetris_input_conditioner.sv
// Debounced left/right move pulses for the game logic.
// Define TETRIS_INPUT_AUTOREPEAT_EN to add hold-to-repeat.
module tetris_input_conditioner
  import tetris_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_r,
  input  logic       btn_l,
  output logic       moveR,
  output logic       moveL,
  output logic [1:0] btn_level
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("tetris_input_conditioner: timing parameters must be >= 1");
  end

  logic lvl_r, lvl_l;
  logic rise_r, rise_l;
  logic press_r, press_l;
  logic both;
  logic move_r_d, move_l_d;
  logic move_r_q, move_l_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_r (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (btn_r),
    .level_o(lvl_r),
    .rise_o (rise_r)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_l (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .raw_i  (btn_l),
    .level_o(lvl_l),
    .rise_o (rise_l)
  );

  assign both    = lvl_r & lvl_l;
  assign press_r = rise_r & ~lvl_l;
  assign press_l = rise_l & ~lvl_r;

`ifdef TETRIS_INPUT_AUTOREPEAT_EN
  localparam int unsigned RW =
    $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  rpt_state_e    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [RW-1:0] rcnt_inc;

  assign rcnt_inc = (rcnt_q == '1) ? rcnt_q : rcnt_q + RW'(1);

  always_comb begin
    state_d  = state_q;
    rcnt_d   = '0;
    move_r_d = 1'b0;
    move_l_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_r) begin
          move_r_d = 1'b1;
          state_d  = HOLD_R;
        end else if (press_l) begin
          move_l_d = 1'b1;
          state_d  = HOLD_L;
        end
      end
      HOLD_R: begin
        if (!lvl_r || lvl_l) begin
          state_d = IDLE;
        end else if (rcnt_q >= DLY_LAST) begin
          move_r_d = 1'b1;
          state_d  = REPEAT_R;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      HOLD_L: begin
        if (!lvl_l || lvl_r) begin
          state_d = IDLE;
        end else if (rcnt_q >= DLY_LAST) begin
          move_l_d = 1'b1;
          state_d  = REPEAT_L;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      REPEAT_R: begin
        if (!lvl_r || lvl_l) begin
          state_d = IDLE;
        end else if (rcnt_q >= PER_LAST) begin
          move_r_d = 1'b1;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      REPEAT_L: begin
        if (!lvl_l || lvl_r) begin
          state_d = IDLE;
        end else if (rcnt_q >= PER_LAST) begin
          move_l_d = 1'b1;
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    // both buttons down is a chord, never a move
    if (both) begin
      state_d  = IDLE;
      rcnt_d   = '0;
      move_r_d = 1'b0;
      move_l_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end
`else
  always_comb begin
    move_r_d = press_r;
    move_l_d = press_l;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_r_q <= 1'b0;
      move_l_q <= 1'b0;
    end else begin
      move_r_q <= move_r_d;
      move_l_q <= move_l_d;
    end
  end

  assign moveR     = move_r_q;
  assign moveL     = move_l_q;
  assign btn_level = {lvl_r, lvl_l};

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Bench for tetris_input_conditioner: segment table, corner sequences
// and random holds against a window/arithmetic reference model.
module tb_tetris_input_conditioner;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_r = 1'b0;
  logic       btn_l = 1'b0;
  logic       moveR, moveL;
  logic [1:0] btn_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tetris_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_r    (btn_r),
    .btn_l    (btn_l),
    .moveR    (moveR),
    .moveL    (moveL),
    .btn_level(btn_level)
  );

  // reference model state
  bit   st_r, st_l, pv_r, pv_l;
  bit   hq_r[$], hq_l[$];
  int   pr_at, pl_at;
  int   ecnt;
  int   pulses_r[$], pulses_l[$];
  logic [1:0] lvl_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // accepted level flips once the last DB synchronized samples all differ
  function automatic bit flips(input bit q[$], input bit st);
    for (int i = q.size() - 1 - DB; i <= q.size() - 2; i++)
      if (q[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    st_r = 0; st_l = 0; pv_r = 0; pv_l = 0;
    hq_r.delete(); hq_l.delete();
    for (int i = 0; i <= DB; i++) begin
      hq_r.push_back(1'b0);
      hq_l.push_back(1'b0);
    end
    pr_at = -1; pl_at = -1;
  endtask

  task automatic cycle();
    bit er, el, nr, nl;
    er = 0; el = 0;
    if (pr_at >= 0 && (!st_r || st_l)) pr_at = -1;
    if (pl_at >= 0 && (!st_l || st_r)) pl_at = -1;
`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    if (pr_at >= 0 && ecnt - pr_at >= DLY &&
        (ecnt - pr_at - DLY) % PER == 0) er = 1;
    if (pl_at >= 0 && ecnt - pl_at >= DLY &&
        (ecnt - pl_at - DLY) % PER == 0) el = 1;
`endif
    if (st_r && !pv_r && !st_l) begin er = 1; pr_at = ecnt; end
    if (st_l && !pv_l && !st_r) begin el = 1; pl_at = ecnt; end
    nr = flips(hq_r, st_r) ? !st_r : st_r;
    nl = flips(hq_l, st_l) ? !st_l : st_l;
    pv_r = st_r; st_r = nr;
    pv_l = st_l; st_l = nl;
    hq_r.push_back(btn_r); void'(hq_r.pop_front());
    hq_l.push_back(btn_l); void'(hq_l.pop_front());
    @(posedge clk); #1;
    chk("moveR", moveR, er);
    chk("moveL", moveL, el);
    chk("btn_level", btn_level, {st_r, st_l});
    chk("exclusive", moveR & moveL, 0);
    if (moveR === 1'b1) pulses_r.push_back(ecnt);
    if (moveL === 1'b1) pulses_l.push_back(ecnt);
    lvl_log.push_back(btn_level);
    ecnt++;
  endtask

  // called #1 after an edge; asserts reset asynchronously
  task automatic reset_pulse(input int n);
    rst_n = 1'b0; #1;
    chk("async_rst", {moveR, moveL, btn_level}, 0);
    model_reset();
    repeat (n) begin
      @(posedge clk); #1;
      chk("in_rst", {moveR, moveL, btn_level}, 0);
    end
    rst_n = 1'b1;
    ecnt = 0;
    pulses_r.delete(); pulses_l.delete(); lvl_log.delete();
  endtask

  typedef struct {
    bit         r;
    bit         l;
    int         n;
    logic [1:0] lvl;
    int         np_r;
    int         np_l;
  } seg_t;

  seg_t tbl[$];
  int   exp_q[$];
  int   got_q[$];

  initial begin
    int b_r, b_l, nz;
    #1;
    reset_pulse(2);

    // table: segments from a fresh reset
    tbl.push_back('{1, 0, 8, 2'b10, 1, 0});
    tbl.push_back('{0, 0, 8, 2'b00, 0, 0});
    tbl.push_back('{0, 1, 8, 2'b01, 0, 1});
    tbl.push_back('{0, 0, 8, 2'b00, 0, 0});
    for (int g = 0; g < 4; g++) begin
      tbl.push_back('{0, 1, 3, 2'b00, 0, 0});
      tbl.push_back('{0, 0, 1, 2'b00, 0, 0});
    end
    tbl.push_back('{1, 1, 8, 2'b11, 0, 0});
    tbl.push_back('{0, 0, 8, 2'b00, 0, 0});
    tbl.push_back('{0, 1, 8, 2'b01, 0, 1});
    tbl.push_back('{1, 1, 8, 2'b11, 0, 0});
    tbl.push_back('{0, 0, 8, 2'b00, 0, 0});
    foreach (tbl[i]) begin
      b_r = pulses_r.size(); b_l = pulses_l.size();
      btn_r = tbl[i].r; btn_l = tbl[i].l;
      repeat (tbl[i].n) cycle();
      chk($sformatf("seg%0d_lvl", i), btn_level, tbl[i].lvl);
      chk($sformatf("seg%0d_npr", i), pulses_r.size() - b_r, tbl[i].np_r);
      chk($sformatf("seg%0d_npl", i), pulses_l.size() - b_l, tbl[i].np_l);
    end

    // right press, exact latencies
    @(posedge clk); #1; reset_pulse(2);
    btn_r = 1; repeat (8) cycle();
    btn_r = 0; repeat (10) cycle();
    chk("r_lvl_e4", lvl_log[4], 2'b00);
    chk("r_lvl_e5", lvl_log[5], 2'b10);
    chk("r_npulse", pulses_r.size(), 1);
    chk("r_pulse_e", pulses_r.size() > 0 ? pulses_r[0] : -1, 6);
    chk("r_no_l", pulses_l.size(), 0);

    // short left glitches
    @(posedge clk); #1; reset_pulse(2);
    repeat (4) begin
      btn_l = 1; repeat (3) cycle();
      btn_l = 0; cycle();
    end
    repeat (6) cycle();
    nz = 0;
    foreach (lvl_log[i]) if (lvl_log[i] != 2'b00) nz++;
    chk("glitch_lvl", nz, 0);
    chk("glitch_pulses", pulses_r.size() + pulses_l.size(), 0);

    // long hold
    @(posedge clk); #1; reset_pulse(2);
    btn_r = 1; repeat (30) cycle();
    btn_r = 0; repeat (8) cycle();
`ifdef TETRIS_INPUT_AUTOREPEAT_EN
    exp_q = '{6, 16, 19, 22, 25, 28};
`else
    exp_q = '{6};
`endif
    got_q.delete();
    foreach (pulses_r[i]) if (pulses_r[i] < 30) got_q.push_back(pulses_r[i]);
    chk("hold_npulse", got_q.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("hold_p%0d", i),
          i < got_q.size() ? got_q[i] : -1, exp_q[i]);

    // chord
    @(posedge clk); #1; reset_pulse(2);
    btn_r = 1; btn_l = 1; repeat (20) cycle();
    chk("chord_lvl", lvl_log[19], 2'b11);
    chk("chord_pulses", pulses_r.size() + pulses_l.size(), 0);
    btn_r = 0; btn_l = 0; repeat (8) cycle();

    // reset during hold
    @(posedge clk); #1; reset_pulse(2);
    btn_r = 1; repeat (17) cycle();
    chk("pre_rst_lvl", btn_level, 2'b10);
    reset_pulse(2);
    repeat (10) cycle();
    chk("post_rst_first",
        pulses_r.size() > 0 ? pulses_r[0] : -1, 6);
    btn_r = 0; repeat (8) cycle();

    // random holds
    @(posedge clk); #1; reset_pulse(2);
    for (int s = 0; s < 80; s++) begin
      btn_r = 1'($urandom_range(0, 1));
      btn_l = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) cycle();
      if ($urandom_range(0, 19) == 0) reset_pulse($urandom_range(1, 3));
    end
    btn_r = 0; btn_l = 0; repeat (10) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_input_conditioner.md
TETRIS_INPUT_CONDITIONER -- requirements
Module: tetris_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a new button level (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 15000000, cycles a lone button is held before its first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1, the single system clock.
REQ-005 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-006 The block SHALL have port btn_r, input, 1, the raw asynchronous right push-button, active high.
REQ-007 The block SHALL have port btn_l, input, 1, the raw asynchronous left push-button, active high.
REQ-008 The block SHALL have port moveR, output, 1, a one-cycle right-move pulse that feeds the game-logic moveR input.
REQ-009 The block SHALL have port moveL, output, 1, a one-cycle left-move pulse that feeds the game-logic moveL input.
REQ-010 The block SHALL have port btn_level, output, 2, the debounced levels: bit 1 is right, bit 0 is left.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer, and no other logic SHALL sample the raw input.
REQ-012 Each channel SHALL keep a stable level and a counter.
- When the synchronized level differs from the stable level, the counter SHALL increment.
- When the synchronized level equals the stable level, the counter SHALL clear to 0.
- When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level SHALL toggle and the counter SHALL clear.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change of btn_level and no pulse.
REQ-014 Latency: if a raw level is first sampled at edge t and held, btn_level SHALL change at edge t+1+DEBOUNCE_CYCLES.
REQ-015 Latency: for a press with the other button released, moveR or moveL SHALL assert at edge t+2+DEBOUNCE_CYCLES, for exactly one cycle.
REQ-016 A rising edge of a stable level SHALL produce one pulse on that channel's move output, provided the other stable level is low.
- A falling edge SHALL produce no pulse.
REQ-017 If both stable levels are high, moveR and moveL SHALL both be held low and all repeat counters SHALL be held at 0.
- This covers simultaneous rising edges in the same cycle.
REQ-018 moveR and moveL SHALL never be high in the same cycle.
REQ-019 Auto-repeat state machine, one per module, with states IDLE, HOLD_R, HOLD_L, REPEAT_R, REPEAT_L:
- IDLE to HOLD_x on the accepted single press (the pulse of REQ-016).
- HOLD_x to REPEAT_x with a pulse after REPEAT_DELAY cycles.
- REPEAT_x emits a pulse every REPEAT_PERIOD cycles.
- Any state returns to IDLE when the held level falls or the other level rises.
REQ-020 The repeat counter width SHALL be the bit count of max(REPEAT_DELAY, REPEAT_PERIOD), and the counter SHALL saturate rather than wrap.
REQ-021 The debounce counter width SHALL be the bit count of DEBOUNCE_CYCLES, and the counter SHALL never wrap.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 Asserting rst_n low SHALL immediately clear the synchronizers, stable levels, counters and state (to IDLE), and drive moveR=0, moveL=0, btn_level=2'b00.
REQ-024 A button held through reset release SHALL be accepted as a new press after the full debounce latency.
REQ-025 Reset asserted mid-repeat SHALL abort the repeat with no trailing pulse.

Configuration
REQ-026 The auto-repeat feature SHALL be controlled by the macro TETRIS_INPUT_AUTOREPEAT_EN.
- Macro defined: REQ-019 and REQ-020 SHALL apply.
- Macro undefined: the state machine and repeat counter SHALL be absent, and only edge pulses per REQ-016 and REQ-017 SHALL be produced.

Structure
REQ-027 The shared package tetris_input_pkg SHALL hold the state-encoding typedef and the default timing constants.
REQ-028 The synchronizer plus debounce logic SHALL be one sub-module, debounce_channel, instantiated twice.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Scenario: btn_r goes high at edge 0 and is held 8 cycles, then released -> btn_level[1] rises at edge 5; moveR is high only at edge 6; moveL stays 0.
REQ-030 Scenario: btn_l pulses high for 3 cycles, repeated 4 times with 1-cycle gaps -> btn_level stays 00; no pulses.
REQ-031 Scenario: btn_r held 30 cycles with the macro defined -> pulses at edges 6, 16, 19, 22, 25, 28; macro undefined -> a pulse at edge 6 only.
REQ-032 Scenario: btn_r and btn_l rise in the same cycle and are held 20 cycles -> btn_level=11; zero pulses on both outputs.
REQ-033 Scenario: btn_r held, rst_n low for 2 cycles at edge 17, then released with btn_r still held -> outputs 0 during reset; the next moveR pulse arrives 6 cycles after release.
